// File: rtl/stream_to_video.sv
// stream_to_video
// Turns the scaler's pushed pixel stream (data + valid, no backpressure) back
// into a raster with hs/vs/de/rgb timing. An elastic FIFO absorbs bursts; a
// three-state machine (IDLE/PRIME/RUN) starts each frame only after the FIFO
// holds PRIME_LEVEL pixels. Underflow and overflow are sticky until rst.
//
// Ports
//   clk         pixel/scaler clock
//   rst         synchronous active-high reset
//   start       one-cycle frame-start pulse from upstream
//   din         input pixel, DATA_WIDTH*CHANNELS bits
//   din_valid   din qualifier (data is pushed, there is no ready)
//   hs, vs      horizontal / vertical sync, active high, registered
//   de          active-video enable, registered
//   rgb         output pixel, zero whenever de is low
//   fifo_level  current FIFO occupancy
//   underflow   sticky: an active-video cycle found the FIFO empty
//   overflow    sticky: a write was dropped because the FIFO was full
module stream_to_video #(
    parameter int H_SYNC      = 44,
    parameter int H_BACK      = 148,
    parameter int H_DISP      = 1920,
    parameter int H_FRONT     = 88,
    parameter int V_SYNC      = 5,
    parameter int V_BACK      = 36,
    parameter int V_DISP      = 1080,
    parameter int V_FRONT     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int CHANNELS    = 3,
    parameter int FIFO_DEPTH  = 2048,
    parameter int PRIME_LEVEL = 64
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [DATA_WIDTH*CHANNELS-1:0]     din,
    input  logic                               din_valid,
    output logic                               hs,
    output logic                               vs,
    output logic                               de,
    output logic [DATA_WIDTH*CHANNELS-1:0]     rgb,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_level,
    output logic                               underflow,
    output logic                               overflow
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = 12;
    localparam int PW      = DATA_WIDTH * CHANNELS;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int LW      = AW + 1;

    localparam logic [HW-1:0] H_ZERO    = HW'(0);
    localparam logic [HW-1:0] H_ONE     = HW'(1);
    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_E  = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT_B   = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0] H_ACT_E   = HW'(H_SYNC + H_BACK + H_DISP);
    localparam logic [VW-1:0] V_ZERO    = VW'(0);
    localparam logic [VW-1:0] V_ONE     = VW'(1);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_E  = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_B   = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] V_ACT_E   = VW'(V_SYNC + V_BACK + V_DISP);
    localparam logic [LW-1:0] LVL_ZERO  = LW'(0);
    localparam logic [LW-1:0] LVL_ONE   = LW'(1);
    localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LVL_PRIME = LW'(PRIME_LEVEL);
    localparam logic [AW-1:0] PTR_ZERO  = AW'(0);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic            start_pending_r, start_pending_s;
    logic            flush_s;
    logic [HW-1:0]   h_cnt_r, h_cnt_s;
    logic [VW-1:0]   v_cnt_r, v_cnt_s;
    logic            in_run_s, frame_end_s;
    logic            hs_nxt_s, vs_nxt_s, de_nxt_s;

    logic [PW-1:0]   mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [LW-1:0]   count_r;
    logic            empty_s, full_s, accept_s, push_s, pop_s, drop_s;

    logic            hs_r, vs_r, de_r;
    logic [PW-1:0]   rgb_r;
    logic            underflow_r, overflow_r;

    // Raster decode of the current counters; everything is gated to RUN.
    always_comb begin
        in_run_s    = (state_r == ST_RUN);
        frame_end_s = in_run_s && (h_cnt_r == H_LAST) && (v_cnt_r == V_LAST);
        hs_nxt_s    = in_run_s && (h_cnt_r < H_SYNC_E);
        vs_nxt_s    = in_run_s && (v_cnt_r < V_SYNC_E);
        de_nxt_s    = in_run_s && (h_cnt_r >= H_ACT_B) && (h_cnt_r < H_ACT_E)
                               && (v_cnt_r >= V_ACT_B) && (v_cnt_r < V_ACT_E);
    end

    // Next-state, pending-start and FIFO-flush decisions.
    always_comb begin
        state_s         = state_r;
        start_pending_s = start_pending_r;
        flush_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // FIFO is held empty while idle
                flush_s = 1'b1;
                if (start) begin
                    state_s = ST_PRIME;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PRIME: begin
                if (start) begin
                    // a fresh start discards whatever was buffered so far
                    flush_s = 1'b1;
                    state_s = ST_PRIME;
                end else if (count_r >= LVL_PRIME) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_PRIME;
                end
            end
            ST_RUN: begin
                if (frame_end_s) begin
                    // a start on the very last cycle still counts as pending;
                    // the FIFO is kept so the next frame can prime quickly
                    start_pending_s = 1'b0;
                    if (start_pending_r || start) begin
                        state_s = ST_PRIME;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else if (start) begin
                    start_pending_s = 1'b1;
                end else begin
                    start_pending_s = start_pending_r;
                end
            end
            default: begin
                state_s         = ST_IDLE;
                start_pending_s = 1'b0;
                flush_s         = 1'b1;
            end
        endcase
    end

    // Raster counters advance only in RUN and sit at zero otherwise.
    always_comb begin
        h_cnt_s = H_ZERO;
        v_cnt_s = V_ZERO;
        if (in_run_s) begin
            if (h_cnt_r == H_LAST) begin
                h_cnt_s = H_ZERO;
                if (v_cnt_r == V_LAST) begin
                    v_cnt_s = V_ZERO;
                end else begin
                    v_cnt_s = v_cnt_r + V_ONE;
                end
            end else begin
                h_cnt_s = h_cnt_r + H_ONE;
                v_cnt_s = v_cnt_r;
            end
        end else begin
            h_cnt_s = H_ZERO;
            v_cnt_s = V_ZERO;
        end
    end

    // FIFO handshake: a pop in the same cycle frees room for a push at full.
    always_comb begin
        empty_s  = (count_r == LVL_ZERO);
        full_s   = (count_r == LVL_FULL);
        pop_s    = de_nxt_s && !empty_s;
        accept_s = din_valid && (state_r != ST_IDLE) && !flush_s;
        push_s   = accept_s && (!full_s || pop_s);
        drop_s   = accept_s && full_s && !pop_s;
    end

    // State, pending start and raster counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            start_pending_r <= 1'b0;
            h_cnt_r         <= H_ZERO;
            v_cnt_r         <= V_ZERO;
        end else begin
            state_r         <= state_s;
            start_pending_r <= start_pending_s;
            h_cnt_r         <= h_cnt_s;
            v_cnt_r         <= v_cnt_s;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst || flush_s) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= LVL_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + LVL_ONE;
                2'b01:   count_r <= count_r - LVL_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Registered video outputs; rgb is the registered FIFO read, so it lands
    // in the same cycle as the de it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_r  <= 1'b0;
            vs_r  <= 1'b0;
            de_r  <= 1'b0;
            rgb_r <= {PW{1'b0}};
        end else begin
            hs_r <= hs_nxt_s;
            vs_r <= vs_nxt_s;
            de_r <= de_nxt_s;
            if (pop_s) begin
                rgb_r <= mem_r[rd_ptr_r];
            end else begin
                rgb_r <= {PW{1'b0}};
            end
        end
    end

    // Sticky error flags, cleared only by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            underflow_r <= underflow_r | (de_nxt_s && empty_s);
            overflow_r  <= overflow_r | drop_s;
        end
    end

    assign hs         = hs_r;
    assign vs         = vs_r;
    assign de         = de_r;
    assign rgb        = rgb_r;
    assign fifo_level = count_r;
    assign underflow  = underflow_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_stream_to_video.sv
// Directed bench for stream_to_video with a small raster:
// H 2/2/8/2 (14 clocks per line), V 1/1/4/1 (7 lines), FIFO 16, prime at 4.
// Pixel values are their index in the stream.
module tb_stream_to_video;

    localparam int W  = 24;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          din_valid;
    logic [W-1:0]  din;
    logic          hs, vs, de;
    logic [W-1:0]  rgb;
    logic [LW-1:0] fifo_level;
    logic          underflow, overflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stream_to_video #(
        .H_SYNC(2), .H_BACK(2), .H_DISP(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
        .DATA_WIDTH(8), .CHANNELS(3), .FIFO_DEPTH(16), .PRIME_LEVEL(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
        .hs(hs), .vs(vs), .de(de), .rgb(rgb), .fifo_level(fifo_level),
        .underflow(underflow), .overflow(overflow)
    );

    // advance one clock and settle just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hs"}, 32'(hs), 32'd0);
        check({tag, "_vs"}, 32'(vs), 32'd0);
        check({tag, "_de"}, 32'(de), 32'd0);
        check({tag, "_rgb"}, 32'(rgb), 32'd0);
        check({tag, "_lvl"}, 32'(fifo_level), 32'd0);
        check({tag, "_uf"}, 32'(underflow), 32'd0);
        check({tag, "_of"}, 32'(overflow), 32'd0);
    endtask

    // start from IDLE and push pixels base+1..base+4; RUN begins on the
    // edge after the level reads 4
    task automatic prime(input int base);
        start = 1'b1; din_valid = 1'b0;
        tick();
        check("prime_start_lvl", 32'(fifo_level), 32'd0);
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            din_valid = 1'b1; din = W'(base + k);
            tick();
            check("prime_lvl", 32'(fifo_level), 32'(k));
        end
        din_valid = 1'b0;
        tick();
        check("prime_hs_low", 32'(hs), 32'd0);
        check("prime_de_low", 32'(de), 32'd0);
    endtask

    // one 98-cycle RUN frame; pixel k of the frame is pushed on a fixed
    // schedule (1..4 already buffered), up to npush pixels
    task automatic run_frame(input int base, input int npush, input bit pulse_start,
                             input bit preload_next, input int lvl_in);
        int lvl, pos, h, v, k;
        bit de_e, uf;
        lvl = lvl_in;
        uf  = 1'b0;
        for (int f = 0; f < 98; f++) begin
            h = f % 14;
            v = f / 14;
            k = 0;
            if (f <= 3)                 k = 5 + f;
            else if (f >= 14 && f <= 21) k = 9 + f - 14;
            else if (f >= 42 && f <= 49) k = 17 + f - 42;
            else if (f >= 56 && f <= 63) k = 25 + f - 56;
            din_valid = 1'b0; din = '0;
            if (k != 0 && k <= npush) begin
                din_valid = 1'b1; din = W'(base + k);
            end
            if (preload_next && f >= 84 && f <= 87) begin
                din_valid = 1'b1; din = W'(base + 33 + f - 84);
            end
            start = pulse_start && (f == 70);
            de_e  = (h >= 4) && (h < 12) && (v >= 2) && (v < 6);
            pos   = (v - 2) * 8 + (h - 4) + 1;
            tick();
            if (de_e && lvl == 0) uf = 1'b1;
            if (de_e && lvl > 0) lvl--;
            if (din_valid) lvl++;
            check("frm_hs", 32'(hs), 32'(h < 2));
            check("frm_vs", 32'(vs), 32'(f < 14));
            check("frm_de", 32'(de), 32'(de_e));
            check("frm_rgb", 32'(rgb), (de_e && pos <= npush) ? 32'(base + pos) : 32'd0);
            check("frm_lvl", 32'(fifo_level), 32'(lvl));
            check("frm_uf", 32'(underflow), 32'(uf));
            check("frm_of", 32'(overflow), 32'd0);
        end
        start = 1'b0; din_valid = 1'b0;
    endtask

    initial begin
        int f, h, v;
        bit de_e;

        // 1: reset with din_valid toggling, then din in IDLE is not stored
        rst = 1'b1; start = 1'b0; din_valid = 1'b0; din = '0;
        for (int i = 0; i < 3; i++) begin
            din_valid = ~din_valid; din = W'(i + 7);
            tick();
        end
        check_all_zero("reset");
        rst = 1'b0; din_valid = 1'b1; din = W'(5);
        tick();
        tick();
        check("idle_drop_lvl", 32'(fifo_level), 32'd0);
        check("idle_hs", 32'(hs), 32'd0);
        din_valid = 1'b0;

        // 2+5: normal frame, start pulsed mid-RUN, next frame preloaded
        prime(0);
        run_frame(0, 32, 1'b1, 1'b1, 4);
        // frame end went to PRIME with 4 buffered: hs rises one cycle later
        tick();
        check("b2b_hs_low", 32'(hs), 32'd0);
        check("b2b_lvl", 32'(fifo_level), 32'd4);

        // 3: back-to-back frame with only 20 pixels -> underflow from pos 21
        run_frame(32, 20, 1'b0, 1'b0, 4);
        tick();
        check("uf_sticky", 32'(underflow), 32'd1);
        check("uf_idle_lvl", 32'(fifo_level), 32'd0);
        tick();
        check("uf_idle_hs", 32'(hs), 32'd0);

        // 4: 32 consecutive pushes after start -> overflow, level capped
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            din_valid = 1'b1; din = W'(i);
            tick();
            check("of_lvl", 32'(fifo_level), 32'((i < 16) ? i : 16));
            check("of_flag", 32'(overflow), 32'(i > 16));
        end
        din_valid = 1'b0;
        // RUN began after the 5th edge; frame cycle f ends at edge 6+f
        for (int q = 33; q <= 54; q++) begin
            f = q - 6; h = f % 14; v = f / 14;
            de_e = (h >= 4) && (h < 12) && (v >= 2) && (v < 6);
            tick();
            check("of_de", 32'(de), 32'(de_e));
            check("of_rgb", 32'(rgb), de_e ? 32'((v - 2) * 8 + (h - 4) + 1) : 32'd0);
        end
        check("of_mid_lvl", 32'(fifo_level), 32'd5);
        check("of_mid_de", 32'(de), 32'd1);
        check("of_uf_still", 32'(underflow), 32'd1);

        // 6: rst mid-line during de clears everything on the next cycle
        rst = 1'b1;
        tick();
        check_all_zero("midrst");
        rst = 1'b0;

        // clean frame after reset, returning to IDLE
        prime(0);
        run_frame(0, 32, 1'b0, 1'b0, 4);
        din_valid = 1'b1; din = W'(99);
        tick();
        check("end_idle_lvl", 32'(fifo_level), 32'd0);
        din_valid = 1'b0;
        tick();
        check("end_idle_hs", 32'(hs), 32'd0);
        check("end_idle_de", 32'(de), 32'd0);
        check("end_flags", 32'({underflow, overflow}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
